bin_to_bcd_seq: RTL
===================

// Module: bin_to_bcd_seq
// PURPOSE
//   Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//   Produces the packed 4-bit BCD digits consumed by the per-digit
//   seven-segment decoders: one decoder instance per nibble of bcd_out.
//   Start/busy/done handshake. Result is held stable between conversions.
// PARAMETERS
//   BIN_W   12  width of binary input; also the number of shift iterations
//   DIGITS  4   number of BCD output digits; must satisfy 10**DIGITS > 2**BIN_W-1
//               (checked at elaboration; a violating build is a fatal error)
// PORTS
//   clk      in   1          system clock; all state on rising edge
//   rst      in   1          asynchronous, active-high reset
//   start    in   1          request conversion of bin_in; sampled only in IDLE
//   bin_in   in   BIN_W      unsigned binary operand; sampled with start
//   busy     out  1          high while a conversion is in progress
//   done     out  1          one-cycle pulse; bcd_out is valid and new
//   bcd_out  out  4*DIGITS   packed BCD; digit i = bcd_out[4*i+3:4*i]; digit 0 = units
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE, busy=0, done=0, bcd_out=0,
//     internal shift/scratch registers=0, counter=0.
//   States: IDLE, SHIFT.
//   IDLE: if start=1 at edge k -> latch bin_in into the shift register,
//     clear the BCD scratch, counter=BIN_W-1, state=SHIFT.
//   SHIFT: one iteration per edge, k+1 .. k+BIN_W:
//     - for each scratch digit >= 5, add 3 (4-bit, no carry out);
//     - then shift {scratch, shift_reg} left by 1 (MSB of bin enters digit 0 LSB);
//     - counter-- ; at the edge where counter==0: bcd_out <= final scratch,
//       done <= 1, state <= IDLE.
//   Latency: done high during the cycle after edge k+BIN_W (BIN_W+1 edges after
//     start is sampled); BIN_W=12 -> 13 edges.
//   busy = (state==SHIFT), registered; high from edge k until edge k+BIN_W.
//   done is high for exactly one cycle, and never together with busy.
//   start while busy: ignored; no queueing; bin_in is not re-sampled.
//   start in the done cycle: accepted (state is IDLE); done still pulses once.
//   bcd_out changes only at completion; it holds its last value otherwise,
//     including during a conversion.
//   Reset mid-conversion: the conversion is aborted; all outputs return to
//     reset values; no done pulse.
//   Every digit of bcd_out is in the range 0..9; no digit is ever A-F.
// STRUCTURE
//   Shared package bcd_pkg: BCD_W=4, state encoding (IDLE=1'b0, SHIFT=1'b1),
//     ADD3_THRESH=4'd5, ADD3_VAL=4'd3.
//   Sub-module bcd_dabble_digit: combinational 4-bit cell, out = (in>=5)?in+3:in;
//     instantiated DIGITS times with generate.
//   Counter width = $clog2(BIN_W).
// TESTING
//   bin_in=0, start pulse -> done pulse after 13 edges, bcd_out=16'h0000.
//   bin_in=4095 -> bcd_out=16'h4095; bin_in=1234 -> 16'h1234; bin_in=9 -> 16'h0009.
//   start during busy with a different bin_in (e.g. 7) -> ignored; result of
//     the first operand only; exactly one done pulse.
//   start asserted in the done cycle (bin_in=100 after 4095) -> second done
//     13 edges later with bcd_out=16'h0100; bcd_out holds 16'h4095 until then.
//   rst pulse at iteration 6 -> busy=0, done=0, bcd_out=0 immediately; the
//     next start converts correctly.
//   Exhaustive sweep 0..4095 vs reference model; every nibble <=9;
//     busy/done never both high.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// digit width, FSM encoding and the double-dabble adjust constants.
package bcd_pkg;

    localparam int BCD_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [BCD_W-1:0] ADD3_THRESH = 4'd5;
    localparam logic [BCD_W-1:0] ADD3_VAL    = 4'd3;

    // Used at elaboration to prove DIGITS decimal digits can hold 2**BIN_W-1.
    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bcd_dabble_digit.sv
// Combinational double-dabble cell: a BCD digit of 5 or more gets 3 added
// before the shift so that it carries correctly into the next decade.
module bcd_dabble_digit
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    output logic [BCD_W-1:0] adjusted
);

    always_comb begin
        adjusted = digit;
        if (digit >= ADD3_THRESH) begin
            adjusted = digit + ADD3_VAL;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock,
// with a start/busy/done handshake and a result held between conversions.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin_in,
    output logic                      busy,
    output logic                      done,
    output logic [BCD_W*DIGITS-1:0]   bcd_out
);

    localparam int BCD_TOT = BCD_W * DIGITS;
    localparam int CNT_W   = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    generate
        if (!(pow10(DIGITS) > ((64'd1 << BIN_W) - 64'd1))) begin : g_digits_too_few
            $fatal(1, "bin_to_bcd_seq: DIGITS=%0d cannot represent 2**%0d-1", DIGITS, BIN_W);
        end
    endgenerate

    state_t               state_q, state_d;
    logic [BIN_W-1:0]     shift_q, shift_d;
    logic [BCD_TOT-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_d, done_d;
    logic [BCD_TOT-1:0]   bcd_d;

    logic [BCD_TOT-1:0]   dabbled;
    logic [BCD_TOT-1:0]   scratch_shifted;
    logic [BIN_W-1:0]     shift_shifted;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            bcd_dabble_digit u_dabble (
                .digit    (scratch_q[BCD_W*g +: BCD_W]),
                .adjusted (dabbled[BCD_W*g +: BCD_W])
            );
        end
    endgenerate

    // The binary MSB enters the units digit; the top adjusted bit is never set
    // for a legal DIGITS, so dropping it loses nothing.
    assign {scratch_shifted, shift_shifted} = {dabbled[BCD_TOT-2:0], shift_q, 1'b0};

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        busy_d    = busy;
        done_d    = 1'b0;
        bcd_d     = bcd_out;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = bin_in;
                    scratch_d = '0;
                    cnt_d     = CNT_LAST;
                    state_d   = SHIFT;
                    busy_d    = 1'b1;
                end
            end
            SHIFT: begin
                shift_d   = shift_shifted;
                scratch_d = scratch_shifted;
                if (cnt_q == '0) begin
                    bcd_d   = scratch_shifted;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd_out   <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            busy      <= busy_d;
            done      <= done_d;
            bcd_out   <= bcd_d;
        end
    end

endmodule
